data_sram_axi_bridge: RTL and testbench

DATA_SRAM_AXI_BRIDGE -- requirements
Module: data_sram_axi_bridge

---
 rtl/data_sram_axi_bridge.sv | 186 ++++++++++++++++++
 tb/tb_data_sram_axi_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_axi_bridge.sv
// Sram-like d-cache port to single-beat AXI4 master bridge, one transaction in flight.
// Optional byte strobes from size/address when SRAM_AXI_WSTRB_EN is defined; full-word otherwise.
module data_sram_axi_bridge #(
  parameter int ID_WIDTH = 4,
  parameter int RD_ID    = 1,
  parameter int WR_ID    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic [31:0]         data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B
  } state_t;

  state_t      state;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        aw_done;
  logic        w_done;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  // Responses and IDs are not used: a single outstanding beat needs no matching.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  assign data_addr_ok = data_req & (state == IDLE);
  assign data_data_ok = wr_reg ? ((state == B) & bvalid)
                               : ((state == R) & rvalid & rlast);
  assign data_rdata   = (state == R) ? rdata : 32'h0;

  assign arid    = ID_WIDTH'(RD_ID);
  assign awid    = ID_WIDTH'(WR_ID);
  assign araddr  = addr_reg;
  assign awaddr  = addr_reg;
  assign arlen   = 8'h0;
  assign awlen   = 8'h0;
  assign arsize  = {1'b0, size_reg};
  assign awsize  = {1'b0, size_reg};
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wdata   = wdata_reg;
  assign wlast   = 1'b1;

`ifdef SRAM_AXI_WSTRB_EN
  // Byte lanes selected by access size and low address bits.
  always_comb begin
    wstrb = 4'b1111;
    unique case (size_reg)
      2'd0:    wstrb = 4'b0001 << addr_reg[1:0];
      2'd1:    wstrb = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end
`else
  assign wstrb = 4'b1111;
`endif

  // Transaction FSM with registered AXI valid/ready outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_reg    <= 1'b0;
      size_reg  <= 2'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_req) begin
            wr_reg    <= data_wr;
            size_reg  <= data_size;
            addr_reg  <= data_addr;
            wdata_reg <= data_wdata;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (data_wr) begin
              state   <= AW_W;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= AR;
              arvalid <= 1'b1;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid & rlast) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        AW_W: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin & w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Bench for data_sram_axi_bridge: AXI slave driven inline, read data scoreboarded.
// Define SRAM_AXI_WSTRB_EN here too when building the strobe variant.
module tb_data_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;
  int ok_cnt = 0;
  int n_done = 0;
  logic [31:0] exp_q[$];

  data_sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_strb(input logic [31:0] a,
                                          input logic [1:0] sz);
    logic [3:0] s;
    s = 4'b1111;
`ifdef SRAM_AXI_WSTRB_EN
    if (sz == 2'd0) begin
      case (a[1:0])
        2'd0: s = 4'b0001;
        2'd1: s = 4'b0010;
        2'd2: s = 4'b0100;
        default: s = 4'b1000;
      endcase
    end else if (sz == 2'd1) begin
      s = a[1] ? 4'b1100 : 4'b0011;
    end
`else
    if (a === 32'hx && sz === 2'bx) s = 4'b0000;
`endif
    return s;
  endfunction

  // Scoreboard: every completion pops the oldest expected read data.
  always @(negedge clk) begin
    if (data_data_ok) begin
      ok_cnt++;
      if (exp_q.size() == 0) chk("ok_unexpected", 32'd1, 32'd0);
      else chk("rdata", data_rdata, exp_q.pop_front());
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d, input int ar_wait,
                         input bit hold);
    data_req = 1'b1;
    data_wr = 1'b0;
    data_addr = a;
    data_size = sz;
    #1;
    chk("rd_addr_ok", data_addr_ok, 1);
    exp_q.push_back(d);
    tick();
    if (!hold) data_req = 1'b0;
    data_addr = ~a;
    data_size = ~sz;
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      #1;
      chk("arvalid_hold", arvalid, 1);
      chk("rd_busy_aok", data_addr_ok, 0);
      tick();
    end
    arready = 1'b1;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, a);
    chk("arsize", arsize, {1'b0, sz});
    chk("arlen", arlen, 0);
    chk("arburst", arburst, 1);
    chk("arid", arid, 1);
    chk("ar_rready", rready, 0);
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rlast = 1'b1;
    rdata = d;
    rresp = 2'($urandom);
    rid = 4'($urandom);
    #1;
    chk("rready", rready, 1);
    chk("rd_ok", data_data_ok, 1);
    chk("r_arvalid", arvalid, 0);
    chk("r_aok", data_addr_ok, 0);
    tick();
    n_done++;
    rvalid = 1'b0;
    rlast = 1'b0;
    rdata = $urandom;
    #1;
    chk("rd_ok_clr", data_data_ok, 0);
    chk("rready_clr", rready, 0);
    chk("rdata_idle", data_rdata, 0);
    chk("b2b_aok", data_addr_ok, {31'b0, hold});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input int aw_wait,
                          input int w_wait);
    bit awd;
    bit wd;
    int c;
    data_req = 1'b1;
    data_wr = 1'b1;
    data_addr = a;
    data_size = sz;
    data_wdata = d;
    #1;
    chk("wr_addr_ok", data_addr_ok, 1);
    exp_q.push_back(32'h0);
    tick();
    data_req = 1'b0;
    data_addr = ~a;
    data_size = ~sz;
    data_wdata = ~d;
    awd = 1'b0;
    wd = 1'b0;
    c = 0;
    while (!(awd && wd) && c < 16) begin
      awready = (c >= aw_wait);
      wready = (c >= w_wait);
      #1;
      chk("awvalid", awvalid, {31'b0, !awd});
      chk("wvalid", wvalid, {31'b0, !wd});
      chk("bready_early", bready, 0);
      chk("wr_ok_early", data_data_ok, 0);
      if (c == 0) begin
        chk("awaddr", awaddr, a);
        chk("wdata", wdata, d);
        chk("awsize", awsize, {1'b0, sz});
        chk("awlen", awlen, 0);
        chk("awburst", awburst, 1);
        chk("wlast", wlast, 1);
        chk("awid", awid, 1);
        chk("wstrb", wstrb, exp_strb(a, sz));
      end
      tick();
      if (awready) awd = 1'b1;
      if (wready) wd = 1'b1;
      c++;
    end
    if (!(awd && wd)) chk("aw_w_timeout", 0, 1);
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    #1;
    chk("bready", bready, 1);
    chk("b_awvalid", awvalid, 0);
    chk("b_wvalid", wvalid, 0);
    chk("b_ok_early", data_data_ok, 0);
    tick();
    bvalid = 1'b1;
    bresp = 2'($urandom);
    bid = 4'($urandom);
    #1;
    chk("wr_ok", data_data_ok, 1);
    tick();
    n_done++;
    bvalid = 1'b0;
    #1;
    chk("wr_ok_clr", data_data_ok, 0);
    chk("bready_clr", bready, 0);
  endtask

  initial begin
    rst = 1'b1;
    data_req = 1'b0;
    data_wr = 1'b0;
    data_size = 2'b0;
    data_addr = 32'h0;
    data_wdata = 32'h0;
    arready = 1'b0;
    rid = 4'h0;
    rdata = 32'h0;
    rresp = 2'b0;
    rlast = 1'b0;
    rvalid = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bid = 4'h0;
    bresp = 2'b0;
    bvalid = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_aok", data_addr_ok, 0);
    chk("rst_dok", data_data_ok, 0);
    chk("rst_rdata", data_rdata, 0);
    rst = 1'b0;
    tick();

    do_read(32'h1FC0_0010, 2'd2, 32'hDEAD_BEEF, 0, 1'b0);
    do_write(32'h8000_0004, 2'd2, 32'h1234_5678, 0, 0);
    do_write(32'h8000_0008, 2'd2, 32'hCAFE_F00D, 3, 0);
    do_write(32'h8000_000C, 2'd2, 32'h0BAD_F00D, 0, 3);
    do_read(32'h0000_0100, 2'd2, 32'hA5A5_5A5A, 2, 1'b0);
    do_read(32'h0000_0200, 2'd2, 32'h1111_2222, 0, 1'b1);
    do_read(32'h0000_0204, 2'd1, 32'h3333_4444, 0, 1'b0);
    do_write(32'h1000_0003, 2'd0, 32'h0000_00AB, 0, 0);
    do_write(32'h1000_0002, 2'd1, 32'h0000_ABCD, 1, 2);
    do_write(32'h1000_0001, 2'd0, 32'h0000_00CD, 2, 2);
    do_write(32'h1000_0000, 2'd1, 32'h0000_1234, 0, 0);

    data_req = 1'b1;
    data_wr = 1'b0;
    data_addr = 32'h0000_1000;
    data_size = 2'd2;
    #1;
    chk("mr_aok", data_addr_ok, 1);
    tick();
    data_req = 1'b0;
    arready = 1'b1;
    #1;
    chk("mr_arvalid", arvalid, 1);
    tick();
    arready = 1'b0;
    rvalid = 1'b0;
    #1;
    chk("mr_rready", rready, 1);
    rst = 1'b1;
    tick();
    chk("mr_rready_clr", rready, 0);
    chk("mr_arvalid_clr", arvalid, 0);
    chk("mr_dok", data_data_ok, 0);
    rst = 1'b0;
    tick();
    chk("mr_no_ok", ok_cnt, n_done);
    do_read(32'h0000_2000, 2'd2, 32'h7654_3210, 0, 1'b0);

    repeat (2) tick();
    chk("ok_count", ok_cnt, n_done);
    chk("q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
